// File: rtl/mem_router.sv
// mem_router: routes single CPU accesses to one of NREG on-chip memory
// regions (RAM, video RAM, BIOS ROM by default) through a parametrised
// base/mask region map. It adds per-region wait states, write protection,
// an open-bus fault flag and a req/ready handshake. There is one clock domain.
//
// Ports
//   clock, reset_n      rising-edge clock, asynchronous active-low reset
//   cpu_req/we/address/wdata   request, sampled only while idle
//   cpu_rdata           read data, valid with cpu_ready, held until next read completion
//   cpu_ready           one-cycle completion pulse
//   cpu_fault           pulses with cpu_ready on a miss or a write to a read-only region
//   mem_address/wdata   latched request address and data, shared by all regions
//   mem_we              one-hot write strobe, one cycle per writable write
//   mem_q               packed region read data (1-cycle BRAM latency)
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | waiting for cpu_req; decode and latch on acceptance
// ACCESS | address/data presented; write strobe; wait counter loaded
// WAIT   | extra wait cycles, counter counts down to terminal count 1
// DONE   | ready pulse, read data / fault presented

module mem_router #(
    parameter int                       ADDR_W      = 20,
    parameter int                       DATA_W      = 8,
    parameter int                       NREG        = 3,
    parameter logic [NREG*ADDR_W-1:0]   REGION_BASE = {20'hF8000, 20'hB8000, 20'h00000},
    parameter logic [NREG*ADDR_W-1:0]   REGION_MASK = {20'hF8000, 20'hFE000, 20'hC0000},
    parameter logic [NREG*4-1:0]        REGION_WAIT = {4'd0, 4'd1, 4'd0},
    parameter logic [NREG-1:0]          REGION_RO   = 3'b100
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic                    cpu_req,
    input  logic                    cpu_we,
    input  logic [ADDR_W-1:0]       cpu_address,
    input  logic [DATA_W-1:0]       cpu_wdata,
    output logic [DATA_W-1:0]       cpu_rdata,
    output logic                    cpu_ready,
    output logic                    cpu_fault,
    output logic [ADDR_W-1:0]       mem_address,
    output logic [DATA_W-1:0]       mem_wdata,
    output logic [NREG-1:0]         mem_we,
    input  logic [NREG*DATA_W-1:0]  mem_q
);

    localparam int IDX_W = (NREG > 1) ? $clog2(NREG) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCESS,
        S_WAIT,
        S_DONE
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic [IDX_W-1:0]    dec_idx;
    logic                dec_hit;
    logic [IDX_W-1:0]    idx_q;
    logic                hit_q;
    logic                we_q;
    logic [3:0]          wait_cnt;
    logic [3:0]          wait_sel;
    logic                ro_sel;
    logic [DATA_W-1:0]   q_sel;
    logic [DATA_W-1:0]   rdata_done;
    logic [DATA_W-1:0]   rdata_hold;

    // Scan from the top index down so the lowest matching region wins.
    always_comb begin
        dec_hit = 1'b0;
        dec_idx = '0;
        for (int i = NREG - 1; i >= 0; i--) begin
            if ((cpu_address & REGION_MASK[i*ADDR_W +: ADDR_W]) == REGION_BASE[i*ADDR_W +: ADDR_W]) begin
                dec_hit = 1'b1;
                dec_idx = IDX_W'(i);
            end
        end
    end

    assign wait_sel   = REGION_WAIT[idx_q*4 +: 4];
    assign ro_sel     = REGION_RO[idx_q];
    assign q_sel      = mem_q[idx_q*DATA_W +: DATA_W];
    assign rdata_done = hit_q ? q_sel : '1;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Strobe, ready and fault are decoded from the state register so an
    // asynchronous reset removes them at once, mid-access included.
    always_comb begin
        state_nxt = state;
        mem_we    = '0;
        cpu_ready = 1'b0;
        cpu_fault = 1'b0;
        cpu_rdata = rdata_hold;
        case (state)
            S_IDLE: begin
                if (cpu_req) begin
                    state_nxt = dec_hit ? S_ACCESS : S_DONE;
                end
            end
            S_ACCESS: begin
                if (we_q && !ro_sel) begin
                    mem_we = NREG'(1) << idx_q;
                end
                state_nxt = (wait_sel != 4'd0) ? S_WAIT : S_DONE;
            end
            S_WAIT: begin
                if (wait_cnt <= 4'd1) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                cpu_ready = 1'b1;
                cpu_fault = !hit_q || (we_q && ro_sel);
                if (!we_q) begin
                    cpu_rdata = rdata_done;
                end
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            mem_address <= '0;
            mem_wdata   <= '0;
            we_q        <= 1'b0;
            idx_q       <= '0;
            hit_q       <= 1'b0;
            wait_cnt    <= 4'd0;
            rdata_hold  <= '1;
        end else begin
            if (state == S_IDLE && cpu_req) begin
                mem_address <= cpu_address;
                mem_wdata   <= cpu_wdata;
                we_q        <= cpu_we;
                idx_q       <= dec_idx;
                hit_q       <= dec_hit;
            end
            // Loaded once, then only decremented while nonzero: never wraps.
            if (state == S_ACCESS) begin
                wait_cnt <= wait_sel;
            end else if (state == S_WAIT && wait_cnt != 4'd0) begin
                wait_cnt <= wait_cnt - 4'd1;
            end
            // A write completion leaves the last read data on cpu_rdata.
            if (state == S_DONE && !we_q) begin
                rdata_hold <= rdata_done;
            end
        end
    end

endmodule

// File: tb/tb_mem_router.sv
`timescale 1ns/1ps
module tb_mem_router;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic        reset_n;
    logic        cpu_req, cpu_we, w5_req;
    logic [19:0] cpu_address;
    logic [7:0]  cpu_wdata;
    logic [7:0]  cpu_rdata, w5_rdata;
    logic        cpu_ready, cpu_fault, w5_ready, w5_fault;
    logic [19:0] mem_address, w5_mem_address;
    logic [7:0]  mem_wdata, w5_mem_wdata;
    logic [2:0]  mem_we, w5_mem_we;
    logic [23:0] mem_q, w5_mem_q;

    mem_router dut (
        .clock(clock), .reset_n(reset_n),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_address(cpu_address), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready), .cpu_fault(cpu_fault),
        .mem_address(mem_address), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_q(mem_q)
    );

    // Second instance with a 5-cycle wait on region 0, for the reset-mid-wait case.
    mem_router #(.REGION_WAIT({4'd0, 4'd1, 4'd5})) u_w5 (
        .clock(clock), .reset_n(reset_n),
        .cpu_req(w5_req), .cpu_we(cpu_we), .cpu_address(cpu_address), .cpu_wdata(cpu_wdata),
        .cpu_rdata(w5_rdata), .cpu_ready(w5_ready), .cpu_fault(w5_fault),
        .mem_address(w5_mem_address), .mem_wdata(w5_mem_wdata), .mem_we(w5_mem_we), .mem_q(w5_mem_q)
    );

    // BRAM models: 256 bytes per region, indexed by the low address byte.
    logic [7:0] bram [3][256];
    logic [7:0] q_r [3];
    logic [7:0] q5_r [3];
    logic       ld_en;
    int         ld_reg;
    logic [7:0] ld_addr, ld_data;

    always @(posedge clock) begin
        for (int i = 0; i < 3; i++) begin
            q_r[i]  <= bram[i][mem_address[7:0]];
            q5_r[i] <= bram[i][w5_mem_address[7:0]];
            if (mem_we[i]) bram[i][mem_address[7:0]] <= mem_wdata;
        end
        if (ld_en) bram[ld_reg][ld_addr] <= ld_data;
    end
    assign mem_q    = {q_r[2], q_r[1], q_r[0]};
    assign w5_mem_q = {q5_r[2], q5_r[1], q5_r[0]};

    // Reference model: region map expressed as address ranges.
    logic [7:0] mm [3][256];
    logic [7:0] last_rd;
    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic void model_decode(input logic [19:0] a, output bit hit, output int idx,
                                         output int wt, output bit ro);
        hit = 1; idx = 0; wt = 0; ro = 0;
        if (a < 20'h40000)                          begin idx = 0; wt = 0; ro = 0; end
        else if (a >= 20'hB8000 && a <= 20'hB9FFF)  begin idx = 1; wt = 1; ro = 0; end
        else if (a >= 20'hF8000)                    begin idx = 2; wt = 0; ro = 1; end
        else hit = 0;
    endfunction

    // One request from IDLE; observes the access up to the ready pulse.
    task automatic txn(input logic we, input logic [19:0] a, input logic [7:0] d,
                       output int lat, output logic flt, output logic [7:0] rd,
                       output logic [2:0] we_or, output int we_cyc, output int bad);
        lat = 0; flt = 0; rd = 0; we_or = 0; we_cyc = 0; bad = 0;
        @(negedge clock);
        chk("idle_no_pulse", {30'd0, cpu_ready, cpu_fault}, 32'd0);
        cpu_req = 1'b1; cpu_we = we; cpu_address = a; cpu_wdata = d;
        for (int c = 1; c <= 30; c++) begin
            @(negedge clock);
            if (c == 1) cpu_req = 1'b0;
            we_or = we_or | mem_we;
            if (mem_we != 3'b000) we_cyc++;
            if (mem_address !== a || (we && mem_wdata !== d)) bad++;
            if (cpu_ready) begin
                lat = c; flt = cpu_fault; rd = cpu_rdata;
                break;
            end
        end
    endtask

    task automatic check_txn(input string tag, input logic we, input logic [19:0] a, input logic [7:0] d,
                             input int e_lat, input logic e_flt, input logic [7:0] e_rd, input logic [2:0] e_we);
        int lat, we_cyc, bad;
        logic flt;
        logic [7:0] rd;
        logic [2:0] we_or;
        txn(we, a, d, lat, flt, rd, we_or, we_cyc, bad);
        chk({tag, "_latency"}, lat, e_lat);
        chk({tag, "_fault"}, {31'd0, flt}, {31'd0, e_flt});
        chk({tag, "_rdata"}, {24'd0, rd}, {24'd0, e_rd});
        chk({tag, "_mem_we"}, {29'd0, we_or}, {29'd0, e_we});
        chk({tag, "_we_cycles"}, we_cyc, (e_we != 3'b000) ? 1 : 0);
        chk({tag, "_addr_stable"}, bad, 0);
    endtask

    // Model-side bookkeeping for a completed access.
    task automatic model_txn(input logic we, input logic [19:0] a, input logic [7:0] d,
                             output int e_lat, output logic e_flt, output logic [7:0] e_rd, output logic [2:0] e_we);
        bit hit, ro;
        int idx, wt;
        model_decode(a, hit, idx, wt, ro);
        e_lat = hit ? 2 + wt : 1;
        e_flt = !hit || (we && ro);
        e_we  = (hit && we && !ro) ? 3'(1 << idx) : 3'b000;
        e_rd  = we ? last_rd : (hit ? mm[idx][a[7:0]] : 8'hFF);
        if (hit && we && !ro) mm[idx][a[7:0]] = d;
        last_rd = e_rd;
    endtask

    typedef struct {
        logic        we;
        logic [19:0] addr;
        logic [7:0]  wdata;
        int          lat;
        logic        fault;
        logic [7:0]  rdata;
        logic [2:0]  wes;
    } vec_t;

    initial begin
        vec_t vecs[$];
        int   lat, mask, seen;
        logic flt;
        logic [7:0] rd, d;
        logic [2:0] wes;
        logic [19:0] a;
        logic w;

        vecs.push_back('{1'b0, 20'h00010, 8'h00, 2, 1'b0, 8'h5A, 3'b000});
        vecs.push_back('{1'b1, 20'hB8005, 8'h41, 3, 1'b0, 8'h5A, 3'b010});
        vecs.push_back('{1'b1, 20'hF8000, 8'h00, 2, 1'b1, 8'h5A, 3'b000});
        vecs.push_back('{1'b0, 20'hFFFF0, 8'h00, 2, 1'b0, 8'hEA, 3'b000});
        vecs.push_back('{1'b0, 20'h50000, 8'h00, 1, 1'b1, 8'hFF, 3'b000});
        vecs.push_back('{1'b0, 20'hB8005, 8'h00, 3, 1'b0, 8'h41, 3'b000});
        vecs.push_back('{1'b0, 20'hC0000, 8'h00, 1, 1'b1, 8'hFF, 3'b000});
        vecs.push_back('{1'b0, 20'hB9FFF, 8'h00, 3, 1'b0, 8'h33, 3'b000});
        vecs.push_back('{1'b1, 20'h3FFFF, 8'h77, 2, 1'b0, 8'h33, 3'b001});
        vecs.push_back('{1'b0, 20'h3FFFF, 8'h00, 2, 1'b0, 8'h77, 3'b000});
        vecs.push_back('{1'b0, 20'hF8000, 8'h00, 2, 1'b0, 8'h83, 3'b000});
        vecs.push_back('{1'b1, 20'hBA000, 8'h12, 1, 1'b1, 8'h83, 3'b000});

        reset_n = 1'b0; cpu_req = 1'b0; w5_req = 1'b0; cpu_we = 1'b0;
        cpu_address = '0; cpu_wdata = '0; ld_en = 1'b0; ld_reg = 0; ld_addr = '0; ld_data = '0;
        last_rd = 8'hFF;

        // Preload BRAM and model with the same contents while in reset.
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 256; i++) begin
                d = 8'(r * 64 + i * 7 + 3);
                if (r == 0 && i == 8'h10) d = 8'h5A;
                if (r == 2 && i == 8'hF0) d = 8'hEA;
                if (r == 1 && i == 8'hFF) d = 8'h33;
                mm[r][i] = d;
                @(negedge clock);
                ld_en = 1'b1; ld_reg = r; ld_addr = 8'(i); ld_data = d;
            end
        end
        @(negedge clock);
        ld_en = 1'b0;

        chk("rst_ready", {31'd0, cpu_ready}, 32'd0);
        chk("rst_fault", {31'd0, cpu_fault}, 32'd0);
        chk("rst_rdata", {24'd0, cpu_rdata}, 32'hFF);
        chk("rst_mem_we", {29'd0, mem_we}, 32'd0);
        chk("rst_mem_address", {12'd0, mem_address}, 32'd0);
        chk("rst_mem_wdata", {24'd0, mem_wdata}, 32'd0);
        @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);

        for (int v = 0; v < vecs.size(); v++) begin
            check_txn($sformatf("vec%0d", v), vecs[v].we, vecs[v].addr, vecs[v].wdata,
                      vecs[v].lat, vecs[v].fault, vecs[v].rdata, vecs[v].wes);
            model_txn(vecs[v].we, vecs[v].addr, vecs[v].wdata, lat, flt, rd, wes);
        end

        // Held request: two back-to-back reads, pulses expected at cycles 2 and 5.
        @(negedge clock);
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_address = 20'h00001;
        mask = 0;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clock);
            if (cpu_ready) begin
                mask = mask | (1 << c);
                if (c == 2) begin
                    chk("held_rdata1", {24'd0, cpu_rdata}, {24'd0, mm[0][1]});
                    cpu_address = 20'h00002;
                end
                if (c == 5) begin
                    chk("held_rdata2", {24'd0, cpu_rdata}, {24'd0, mm[0][2]});
                    cpu_req = 1'b0;
                end
            end
            if (c == 4) chk("held_addr2", {12'd0, mem_address}, 32'h00002);
        end
        cpu_req = 1'b0;
        chk("held_ready_cycles", mask, 32'h24);
        last_rd = mm[0][2];

        // Randomized traffic against the model.
        for (int n = 0; n < 300; n++) begin
            case ($urandom_range(0, 3))
                0: a = {2'b00, 18'($urandom)};
                1: a = 20'hB8000 | 20'($urandom_range(0, 20'h1FFF));
                2: a = 20'hF8000 | 20'($urandom_range(0, 20'h7FFF));
                default: a = 20'($urandom);
            endcase
            w = 1'($urandom);
            d = 8'($urandom);
            model_txn(w, a, d, lat, flt, rd, wes);
            check_txn($sformatf("rnd%0d", n), w, a, d, lat, flt, rd, wes);
        end

        // Reset during the wait phase of a W=5 read.
        @(negedge clock);
        cpu_we = 1'b0; cpu_address = 20'h00000; w5_req = 1'b1;
        seen = 0;
        for (int c = 1; c <= 3; c++) begin
            @(negedge clock);
            if (c == 1) w5_req = 1'b0;
            if (w5_ready) seen++;
        end
        reset_n = 1'b0;
        #1;
        chk("rstw_ready", {31'd0, w5_ready}, 32'd0);
        chk("rstw_rdata", {24'd0, w5_rdata}, 32'hFF);
        chk("rstw_main_rdata", {24'd0, cpu_rdata}, 32'hFF);
        chk("rstw_mem_we", {29'd0, w5_mem_we}, 32'd0);
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        for (int c = 0; c < 12; c++) begin
            @(negedge clock);
            if (w5_ready) seen++;
        end
        chk("rstw_no_ready", seen, 0);

        w5_req = 1'b1; cpu_address = 20'h00000;
        lat = 0;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clock);
            if (c == 1) w5_req = 1'b0;
            if (w5_ready) begin
                lat = c; rd = w5_rdata; flt = w5_fault;
                break;
            end
        end
        chk("rstw_after_latency", lat, 7);
        chk("rstw_after_rdata", {24'd0, rd}, {24'd0, mm[0][0]});
        chk("rstw_after_fault", {31'd0, flt}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_router.md
# mem_router

Parametrised memory-bus router between the CPU core and the on-chip memory blocks: general RAM, CGA video RAM and BIOS ROM. It replaces the fixed combinational `casex` decoder with an N-region map taken from parameters. It adds per-region wait states, write protection, an open-bus fault flag and a req/ready handshake. All routing happens on one clock domain, the CPU clock, and the router sits between the CPU and the synchronous BRAMs.

## Interface
Parameters:
- `ADDR_W`, 20, CPU address width.
- `DATA_W`, 8, data width.
- `NREG`, 3, number of regions.
- `REGION_BASE`, {20'hF8000, 20'hB8000, 20'h00000}, packed `NREG*ADDR_W`. Region i sits in bits [i*ADDR_W +: ADDR_W].
- `REGION_MASK`, {20'hF8000, 20'hFE000, 20'hC0000}, packed `NREG*ADDR_W`. These are the significant address bits.
- `REGION_WAIT`, {4'd0, 4'd1, 4'd0}, packed `NREG*4`. Extra wait cycles per region, 0–15.
- `REGION_RO`, 3'b100, bit i set means region i is read-only.

Ports:
- `clock` in 1: single clock; all logic on its rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `cpu_req` in 1: access request, sampled only in IDLE.
- `cpu_we` in 1: 1 = write, 0 = read; sampled with `cpu_req`.
- `cpu_address` in `ADDR_W`: sampled with `cpu_req`.
- `cpu_wdata` in `DATA_W`: sampled with `cpu_req`.
- `cpu_rdata` out `DATA_W`: read data; valid when `cpu_ready`=1 and held until the next completion.
- `cpu_ready` out 1: one-cycle completion pulse.
- `cpu_fault` out 1: pulses together with `cpu_ready` on an unmapped access or a write to a read-only region.
- `mem_address` out `ADDR_W`: registered address, shared by all regions.
- `mem_wdata` out `DATA_W`: registered write data, shared.
- `mem_we` out `NREG`: one-hot write strobe.
- `mem_q` in `NREG*DATA_W`: region read data, from BRAM with 1-cycle read latency.

## Operation
- **Decode.** Region i matches when `(addr & MASK[i]) == BASE[i]`. Lowest index wins on overlap. Decode runs on `cpu_address` in IDLE, and the selected index and a hit flag are latched.
- **IDLE**
  - `cpu_req`=1 latches address, data, we, region index and hit.
  - Miss: go to DONE.
  - Hit: go to ACCESS.
- **ACCESS (1 cycle)**
  - `mem_address` and `mem_wdata` already hold the latched values.
  - `mem_we[i]`=1 for this cycle only, if the access is a write and `RO[i]`=0.
  - Load the wait counter with `WAIT[i]`.
  - Go to WAIT if `WAIT[i]`≠0, otherwise go to DONE.
- **WAIT.** Decrement the counter each cycle and go to DONE when it reaches 1.
- **DONE (1 cycle)**
  - `cpu_ready`=1.
  - `cpu_rdata` ← `mem_q[i]` on a read hit, FF on a miss.
  - `cpu_rdata` is unchanged on a write.
  - `cpu_fault` = miss OR (write AND RO).
  - Next state is IDLE.
- **Ignored requests.** `cpu_req` in ACCESS, WAIT or DONE is ignored. The CPU keeps `cpu_req` high until it sees `cpu_ready`. A still-high `cpu_req` is re-accepted in the IDLE cycle after DONE.
- **Blocked writes.** A write to an RO region never asserts any `mem_we` bit. Its timing is identical to a normal access.
- **Widths.**
  - The wait counter is 4 bits and never wraps; it is only loaded and decremented while nonzero.
  - `mem_q` slices are `DATA_W` each; region i is `[i*DATA_W +: DATA_W]`.

## Timing
- **Reset.** Asynchronous `reset_n`=0 forces, immediately:
  - state IDLE
  - `cpu_ready`=0, `cpu_fault`=0
  - `cpu_rdata`=FF
  - `mem_we`=0, `mem_address`=0, `mem_wdata`=0
- **Reset mid-access.** Reset during ACCESS or WAIT aborts the access with no ready pulse. A `mem_we` strobe in progress drops immediately.
- **Latency** (cycle 0 is the edge that samples `cpu_req` in IDLE):
  - Hit: `cpu_ready` is high during cycle 2+`WAIT[i]`. That is 2 cycles for W=0, which covers the BRAM's 1-cycle read latency.
  - Miss: `cpu_ready` is high during cycle 1.
- **Throughput.** Back-to-back accesses with W=0 complete one every 3 cycles, and one every 2 cycles for misses.
- **Register stability.** `mem_address` and `mem_wdata` are stable from cycle 1 through DONE and change only on acceptance.
- **Strobe width.** `mem_we` is high for exactly one cycle per accepted writable write.
- **Single-cycle pulses.** `cpu_ready` and `cpu_fault` are never high for two consecutive cycles.

## Test plan
- **Read, no wait.** Read 0x00010 with region0 `mem_q`=0x5A. Expect `mem_address`=0x00010 from cycle 1, `cpu_ready`=1 at cycle 2, `cpu_rdata`=0x5A, `cpu_fault`=0, `mem_we` always 0.
- **Write with wait state.** Write 0x41 to 0xB8005 (W=1). Expect `mem_we`=3'b010 at cycle 1 only, `mem_wdata`=0x41, `cpu_ready` at cycle 3, `cpu_fault`=0.
- **Write to ROM.** Write 0x00 to 0xF8000. Expect `mem_we` to stay 0, `cpu_ready` and `cpu_fault` both high at cycle 2. Then read 0xFFFF0 with region2 `mem_q`=0xEA: `cpu_rdata`=0xEA, `cpu_fault`=0.
- **Unmapped read.** Read 0x50000. Expect `cpu_ready` and `cpu_fault` at cycle 1, `cpu_rdata`=0xFF, no `mem_we`.
- **Back-to-back with held request.** Hold `cpu_req`=1 continuously across reads to 0x00001 and then 0x00002 (W=0). Expect ready pulses at cycles 2 and 5, with no duplicate acceptance during ACCESS or DONE.
- **Reset mid-wait.** Override `REGION_WAIT[0]`=5 and read 0x00000. Assert `reset_n`=0 at cycle 3. Expect no `cpu_ready`, `cpu_rdata`=0xFF, and the next request to complete normally after release.
